// File: rtl/ksynth_pkg.sv
// Shared types and constants for the synth voice scheduler.
// Provides the scheduler state encoding, default sizes and the voice index width helper.
package ksynth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_PHASE_W    = 32;

  // Index width never drops below one bit, even for a single voice.
  function automatic int vidx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/voice_regfile.sv
// Per-voice increment, gate and phase storage with one config write port,
// a combinational read of the voice being swept and a phase write-back port.
module voice_regfile
  import ksynth_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int VIDX_W     = vidx_w(DEF_NUM_VOICES)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               wr_en,
  input  logic [VIDX_W-1:0]  wr_voice,
  input  logic [PHASE_W-1:0] wr_inc,
  input  logic               wr_gate,
  input  logic [VIDX_W-1:0]  rd_voice,
  output logic [PHASE_W-1:0] rd_inc,
  output logic               rd_gate,
  output logic [PHASE_W-1:0] rd_phase,
  input  logic               ph_we,
  input  logic [VIDX_W-1:0]  ph_voice,
  input  logic [PHASE_W-1:0] ph_data
);

  logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0]    inc_d   [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] gate_d;

  // Out-of-range voice indices match no entry, so such writes change nothing.
  // Phase survives a write only when the voice stays gated (glide).
  always_comb begin
    inc_d   = inc_q;
    gate_d  = gate_q;
    phase_d = phase_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (ph_we && (ph_voice == VIDX_W'(i))) begin
        phase_d[i] = ph_data;
      end
      if (wr_en && (wr_voice == VIDX_W'(i))) begin
        inc_d[i]  = wr_inc;
        gate_d[i] = wr_gate;
        if (!(gate_q[i] && wr_gate)) begin
          phase_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    rd_inc   = '0;
    rd_gate  = 1'b0;
    rd_phase = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rd_voice == VIDX_W'(i)) begin
        rd_inc   = inc_q[i];
        rd_gate  = gate_q[i];
        rd_phase = phase_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        inc_q[i]   <= '0;
        phase_q[i] <= '0;
      end
      gate_q <= '0;
    end else begin
      inc_q   <= inc_d;
      phase_q <= phase_d;
      gate_q  <= gate_d;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexed phase accumulator: each sample tick sweeps every voice in index
// order, one per clock, and streams the updated phases to the wavetable stage.
module voice_scheduler
  import ksynth_pkg::*;
#(
  parameter int  NUM_VOICES = DEF_NUM_VOICES,
  parameter int  PHASE_W    = DEF_PHASE_W,
  localparam int VIDX_W     = vidx_w(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               tick,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [VIDX_W-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic               cfg_gate,
  input  logic               ovr_clr,
  output logic               out_valid,
  output logic [VIDX_W-1:0]  out_voice,
  output logic [PHASE_W-1:0] out_phase,
  output logic               out_wrap,
  output logic               out_last,
  output logic               busy,
  output logic               overrun
);

  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

  state_e             state_q, state_d;
  logic [VIDX_W-1:0]  v_q, v_d;
  logic               out_valid_q, out_valid_d;
  logic [VIDX_W-1:0]  out_voice_q, out_voice_d;
  logic [PHASE_W-1:0] out_phase_q, out_phase_d;
  logic               out_wrap_q, out_wrap_d;
  logic               out_last_q, out_last_d;
  logic               overrun_q, overrun_d;

  logic [PHASE_W-1:0] rd_inc;
  logic               rd_gate;
  logic [PHASE_W-1:0] rd_phase;
  logic [PHASE_W:0]   sum;
  logic [PHASE_W-1:0] new_phase;
  logic               new_wrap;
  logic               ph_we;
  logic               wr_en;

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign wr_en     = cfg_valid && cfg_ready;

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .VIDX_W     (VIDX_W)
  ) u_regfile (
    .clk      (clk),
    .clr_n    (clr_n),
    .wr_en    (wr_en),
    .wr_voice (cfg_voice),
    .wr_inc   (cfg_inc),
    .wr_gate  (cfg_gate),
    .rd_voice (v_q),
    .rd_inc   (rd_inc),
    .rd_gate  (rd_gate),
    .rd_phase (rd_phase),
    .ph_we    (ph_we),
    .ph_voice (v_q),
    .ph_data  (new_phase)
  );

  // A set of the sticky overrun flag takes priority over a coincident clear.
  always_comb begin
    sum       = {1'b0, rd_phase} + {1'b0, rd_inc};
    new_phase = rd_gate ? sum[PHASE_W-1:0] : rd_phase;
    new_wrap  = rd_gate & sum[PHASE_W];

    state_d     = state_q;
    v_d         = v_q;
    ph_we       = 1'b0;
    out_valid_d = 1'b0;
    out_voice_d = out_voice_q;
    out_phase_d = out_phase_q;
    out_wrap_d  = out_wrap_q;
    out_last_d  = out_last_q;
    overrun_d   = ovr_clr ? 1'b0 : overrun_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          v_d     = '0;
        end
      end
      SCAN: begin
        ph_we       = 1'b1;
        out_valid_d = 1'b1;
        out_voice_d = v_q;
        out_phase_d = new_phase;
        out_wrap_d  = new_wrap;
        out_last_d  = (v_q == LAST_V);
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (v_q == LAST_V) begin
          state_d = IDLE;
          v_d     = '0;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        v_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      out_voice_q <= '0;
      out_phase_q <= '0;
      out_wrap_q  <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      out_voice_q <= out_voice_d;
      out_phase_q <= out_phase_d;
      out_wrap_q  <= out_wrap_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_voice = out_voice_q;
  assign out_phase = out_phase_q;
  assign out_wrap  = out_wrap_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: stimulus pushes expected sweep results from
// an array-based reference model, a negedge monitor pops and compares every output.
module tb_voice_scheduler;

  localparam int NV = 6;
  localparam int PW = 32;
  localparam int VW = 3;
  localparam longint unsigned MODV = 64'd1 << PW;

  logic          clk;
  logic          clr_n;
  logic          tick;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [VW-1:0] cfg_voice;
  logic [PW-1:0] cfg_inc;
  logic          cfg_gate;
  logic          ovr_clr;
  logic          out_valid;
  logic [VW-1:0] out_voice;
  logic [PW-1:0] out_phase;
  logic          out_wrap;
  logic          out_last;
  logic          busy;
  logic          overrun;

  voice_scheduler #(
    .NUM_VOICES (NV),
    .PHASE_W    (PW)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .tick      (tick),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_voice (cfg_voice),
    .cfg_inc   (cfg_inc),
    .cfg_gate  (cfg_gate),
    .ovr_clr   (ovr_clr),
    .out_valid (out_valid),
    .out_voice (out_voice),
    .out_phase (out_phase),
    .out_wrap  (out_wrap),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  typedef struct {
    int              voice;
    longint unsigned phase;
    bit              wrap;
    bit              last;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: what each voice holds according to the behavioural rules.
  longint unsigned m_inc   [NV];
  longint unsigned m_phase [NV];
  bit              m_gate  [NV];
  bit              m_ov;

  int              pw_voice;
  longint unsigned pw_inc;
  bit              pw_gate;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void check_output(input string name, input logic [63:0] act,
                                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_inc[i]   = 0;
      m_phase[i] = 0;
      m_gate[i]  = 1'b0;
    end
    m_ov = 1'b0;
  endfunction

  function automatic void model_write(input int voice, input longint unsigned inc,
                                      input bit gate);
    if (voice < NV) begin
      if (!(m_gate[voice] && gate)) m_phase[voice] = 0;
      m_inc[voice]  = inc;
      m_gate[voice] = gate;
    end
  endfunction

  // Tick seen in cycle n: voice k appears in cycle n+2+k.
  function automatic void model_sweep(input int n);
    exp_t e;
    longint unsigned s;
    for (int k = 0; k < NV; k++) begin
      e.wrap = 1'b0;
      if (m_gate[k]) begin
        s          = m_phase[k] + m_inc[k];
        e.wrap     = (s >= MODV);
        m_phase[k] = s % MODV;
      end
      e.voice = k;
      e.phase = m_phase[k];
      e.last  = (k == NV - 1);
      e.cyc   = n + 2 + k;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: every presented result must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (clr_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("out_voice", out_voice, e.voice);
        check_output("out_phase", out_phase, e.phase);
        check_output("out_wrap", out_wrap, e.wrap);
        check_output("out_last", out_last, e.last);
        check_output("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg();
    cfg_valid = 1'b1;
    cfg_voice = VW'(pw_voice);
    cfg_inc   = PW'(pw_inc);
    cfg_gate  = pw_gate;
  endtask

  task automatic idle_write(input int voice, input longint unsigned inc, input bit gate);
    pw_voice = voice;
    pw_inc   = inc;
    pw_gate  = gate;
    drive_cfg();
    check_output("cfg_ready_idle", cfg_ready, 1);
    step();
    model_write(voice, inc, gate);
    cfg_valid = 1'b0;
  endtask

  task automatic clear_overrun();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    m_ov    = 1'b0;
    check_output("overrun_cleared", overrun, 0);
  endtask

  // One full sweep from IDLE. write_now: config write alongside the tick.
  // hold_cfg: cfg_valid raised during the sweep. extra_at: busy tick at that cycle.
  task automatic apply_stimulus(input bit write_now, input bit hold_cfg,
                                input int extra_at, input bit clr_at);
    int n;
    n = cyc;
    if (write_now) begin
      drive_cfg();
      model_write(pw_voice, pw_inc, pw_gate);
    end
    tick = 1'b1;
    model_sweep(n);
    step();
    tick      = 1'b0;
    cfg_valid = 1'b0;
    for (int j = 1; j <= NV + 1; j++) begin
      check_output("busy", busy, (j <= NV));
      check_output("cfg_ready", cfg_ready, (j > NV));
      check_output("overrun", overrun, m_ov);
      if (hold_cfg && j == 1) drive_cfg();
      if (j == extra_at) begin
        tick    = 1'b1;
        ovr_clr = clr_at;
        step();
        tick    = 1'b0;
        ovr_clr = 1'b0;
        m_ov    = 1'b1;
      end else begin
        step();
      end
      if (hold_cfg && j == NV + 1) begin
        model_write(pw_voice, pw_inc, pw_gate);
        cfg_valid = 1'b0;
      end
    end
    check_output("overrun_end", overrun, m_ov);
  endtask

  task automatic reset_mid_sweep();
    int n;
    n    = cyc;
    tick = 1'b1;
    model_sweep(n);
    step();
    step();
    tick = 1'b0;
    m_ov = 1'b1;
    check_output("overrun_before_reset", overrun, 1);
    step();
    step();
    clr_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_cfg_ready", cfg_ready, 1);
    check_output("rst_out_phase", out_phase, 0);
    step();
    step();
    clr_n = 1'b1;
    step();
  endtask

  task automatic random_pw();
    pw_voice = $urandom_range(0, 7);
    pw_inc   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 255))
                                           : longint'($urandom);
    pw_gate  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr_n     = 1'b0;
    tick      = 1'b0;
    cfg_valid = 1'b0;
    cfg_voice = '0;
    cfg_inc   = '0;
    cfg_gate  = 1'b0;
    ovr_clr   = 1'b0;
    pw_voice  = 0;
    pw_inc    = 0;
    pw_gate   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_overrun", overrun, 0);
    check_output("reset_cfg_ready", cfg_ready, 1);
    check_output("reset_out_phase", out_phase, 0);
    check_output("reset_out_last", out_last, 0);
    clr_n = 1'b1;
    step();

    $display("[TB] basic sweep");
    idle_write(0, 64'h1000_0000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] wrap on voice 2");
    idle_write(2, 64'h8000_0000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] overrun handling");
    apply_stimulus(1'b0, 1'b0, 3, 1'b0);
    clear_overrun();
    apply_stimulus(1'b0, 1'b0, 2, 1'b1);
    clear_overrun();
    apply_stimulus(1'b0, 1'b0, NV, 1'b0);
    clear_overrun();

    $display("[TB] config handshake");
    pw_voice = 4; pw_inc = 64'h77; pw_gate = 1'b1;
    apply_stimulus(1'b0, 1'b1, 0, 1'b0);
    pw_voice = 1; pw_inc = 64'h5; pw_gate = 1'b1;
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    idle_write(7, 64'hDEAD_BEEF, 1'b0);
    idle_write(6, 64'h1234_5678, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] gate handling");
    idle_write(3, 64'h100, 1'b1);
    repeat (4) apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    idle_write(3, 64'h200, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    idle_write(3, 64'h200, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    idle_write(3, 64'h200, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] reset mid-sweep");
    reset_mid_sweep();
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      random_pw();
      case ($urandom_range(0, 4))
        0: idle_write(pw_voice, pw_inc, pw_gate);
        1: apply_stimulus(1'b0, 1'b0, $urandom_range(0, NV), $urandom_range(0, 1));
        2: apply_stimulus(1'b1, 1'b0, 0, 1'b0);
        3: apply_stimulus(1'b0, 1'b1, $urandom_range(0, NV), 1'b0);
        default: clear_overrun();
      endcase
    end

    repeat (4) step();
    check_output("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
